// File: rtl/io_test_scope.sv
// io_test_scope: a small logic-analyser style capture block on the IO bus.
//
// A 16-bit test bus (ATest16p) is written into a circular sample buffer
// while armed. A masked compare (the trigger) records where the event
// happened. A programmable number of post-trigger samples is then taken
// before capture stops. Software reads the buffer oldest-first through a
// DATA register that auto-increments.
//
// IO protocol: one access per clock, no handshake.
//  - An access is a read when AIoRdSize != 0 and a write when AIoWrSize != 0.
//  - AIoAddrAck/AIoAddrErr/AIoMiso are combinational from the current
//    address, strobes and registered state. The read data is valid in the
//    same cycle as the access.
//  - Side effects (CTRL latch, DATA pointer advance) happen at the rising
//    edge, and only when AClkHEn is high and the access is not an error.
//
// Register map:
//  CAddrBase   W: CTRL   [15:0] mask, [31:16] value, [39:32] post count,
//                        [62] abort, [63] arm
//              R: STATUS [1:0] state, [15:8] TrigIdx, [23:16] write ptr,
//                        [31:24] read ptr, [32] wrapped
//  CAddrBase+1 R: DATA   [15:0] sample, [23:16] read ptr (zero unless DONE)
//
// Ports:
//  AClkH, AResetHN (sync, active-low), AClkHEn (clock enable)
//  AIoAddr, AIoMosi, AIoWrSize, AIoRdSize -> IO request
//  AIoMiso, AIoAddrAck, AIoAddrErr        <- IO response
//  ATest16p                               -> sampled test bus
//
// The FSM state is always observable through STATUS[1:0].

module io_test_scope #(
  parameter logic [15:0] CAddrBase  = 16'h0000,
  parameter int          CDepthLog2 = 6
) (
  input  logic        AClkH,
  input  logic        AResetHN,
  input  logic        AClkHEn,
  input  logic [15:0] AIoAddr,
  output logic [63:0] AIoMiso,
  input  logic [63:0] AIoMosi,
  input  logic [3:0]  AIoWrSize,
  input  logic [3:0]  AIoRdSize,
  output logic        AIoAddrAck,
  output logic        AIoAddrErr,
  input  logic [15:0] ATest16p
);

  localparam int          CDepth    = 1 << CDepthLog2;
  localparam logic [15:0] CAddrData = CAddrBase + 16'd1;

  typedef logic [CDepthLog2-1:0] TPtr;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } TState;

  TState       state, stateNext;
  TPtr         wrPtr, wrPtrNext;
  TPtr         rdPtr, rdPtrNext;
  TPtr         trigIdx, trigIdxNext;
  TPtr         cnt, cntNext;
  TPtr         postCnt;
  logic        wrapped, wrappedNext;
  logic [15:0] trigMask, trigValue;
  logic [15:0] mem [CDepth];

  // ---------------------------------------------------------------- decode
  logic hitCtrl, hitData, isWr, isRd, accOk;
  logic ctrlWr, statusRd, dataRd;
  logic sampling, trigHit;
  TPtr  wrPtrInc;

  assign hitCtrl    = (AIoAddr == CAddrBase);
  assign hitData    = (AIoAddr == CAddrData);
  assign isWr       = |AIoWrSize;
  assign isRd       = |AIoRdSize;
  assign AIoAddrAck = (hitCtrl | hitData) & (isWr | isRd);
  // Mixed read+write, or any write to the read-only DATA register.
  assign AIoAddrErr = AIoAddrAck & ((isWr & isRd) | (isWr & hitData));
  assign accOk      = AIoAddrAck & ~AIoAddrErr;
  assign ctrlWr     = accOk & hitCtrl & isWr;
  assign statusRd   = accOk & hitCtrl & isRd;
  assign dataRd     = accOk & hitData & isRd;

  assign sampling = (state == StArmed) || (state == StPost);
  assign trigHit  = ((ATest16p ^ trigValue) & trigMask) == 16'h0000;
  assign wrPtrInc = wrPtr + TPtr'(1);

  // MOSI bits with no function here; grouped so they are visibly ignored.
  logic unusedBits;
  assign unusedBits = ^{AIoMosi[61:40], AIoMosi[39:32]};

  // ------------------------------------------------------ next-state logic
  always_comb begin
    stateNext   = state;
    wrPtrNext   = wrPtr;
    rdPtrNext   = rdPtr;
    trigIdxNext = trigIdx;
    cntNext     = cnt;
    wrappedNext = wrapped;

    if (sampling) begin
      wrPtrNext = wrPtrInc;
      if (wrPtrInc == '0) wrappedNext = 1'b1;
    end

    case (state)
      StArmed: begin
        if (trigHit) begin
          trigIdxNext = wrPtr;
          if (postCnt == '0) begin
            stateNext = StDone;
          end else begin
            stateNext = StPost;
            cntNext   = postCnt;
          end
        end
      end
      StPost: begin
        cntNext = cnt - TPtr'(1);
        if (cnt == TPtr'(1)) stateNext = StDone;
      end
      StDone: begin
        if (dataRd) rdPtrNext = rdPtr + TPtr'(1);
      end
      default: ;
    endcase

    // Oldest sample first: after a wrap the oldest entry is the one about
    // to be overwritten, i.e. the updated write pointer.
    if (stateNext == StDone && state != StDone)
      rdPtrNext = wrappedNext ? wrPtrNext : '0;

    // A CTRL write overrides the FSM but the sample of this cycle has
    // already been handled above under the old state.
    if (ctrlWr) begin
      if (AIoMosi[62]) begin
        stateNext = StIdle;
      end else if (AIoMosi[63]) begin
        stateNext   = StArmed;
        wrPtrNext   = '0;
        rdPtrNext   = '0;
        wrappedNext = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------- registers
  always_ff @(posedge AClkH) begin
    if (!AResetHN) begin
      state     <= StIdle;
      wrPtr     <= '0;
      rdPtr     <= '0;
      trigIdx   <= '0;
      cnt       <= '0;
      wrapped   <= 1'b0;
      trigMask  <= '0;
      trigValue <= '0;
      postCnt   <= '0;
    end else if (AClkHEn) begin
      state   <= stateNext;
      wrPtr   <= wrPtrNext;
      rdPtr   <= rdPtrNext;
      trigIdx <= trigIdxNext;
      cnt     <= cntNext;
      wrapped <= wrappedNext;
      if (ctrlWr) begin
        trigMask  <= AIoMosi[15:0];
        trigValue <= AIoMosi[31:16];
        postCnt   <= AIoMosi[32 +: CDepthLog2];
      end
    end
  end

  // Sample buffer, not reset.
  always_ff @(posedge AClkH) begin
    if (AResetHN && AClkHEn && sampling) mem[wrPtr] <= ATest16p;
  end

  // ------------------------------------------------------------- read data
  always_comb begin
    AIoMiso = '0;
    if (statusRd) begin
      AIoMiso[1:0]   = state;
      AIoMiso[15:8]  = 8'(trigIdx);
      AIoMiso[23:16] = 8'(wrPtr);
      AIoMiso[31:24] = 8'(rdPtr);
      AIoMiso[32]    = wrapped;
    end else if (dataRd && state == StDone) begin
      AIoMiso[15:0]  = mem[rdPtr];
      AIoMiso[23:16] = 8'(rdPtr);
    end
  end

endmodule

// File: tb/tb_io_test_scope.sv
// Testbench for io_test_scope: IO decode vectors from a table, directed
// capture scenarios and randomized captures checked against a sample-list
// model of the capture rules.

module tb_io_test_scope;

  localparam logic [15:0] Base  = 16'h0120;
  localparam int          DLog2 = 6;
  localparam int          D     = 1 << DLog2;

  // ------------------------------------------------------ clock and reset
  logic clk;
  logic rstN;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        clkEn;
  logic [15:0] ioAddr;
  logic [63:0] ioMiso;
  logic [63:0] ioMosi;
  logic [3:0]  ioWr;
  logic [3:0]  ioRd;
  logic        ioAck;
  logic        ioErr;
  logic [15:0] test;

  io_test_scope #(.CAddrBase(Base), .CDepthLog2(DLog2)) dut (
    .AClkH     (clk),
    .AResetHN  (rstN),
    .AClkHEn   (clkEn),
    .AIoAddr   (ioAddr),
    .AIoMiso   (ioMiso),
    .AIoMosi   (ioMosi),
    .AIoWrSize (ioWr),
    .AIoRdSize (ioRd),
    .AIoAddrAck(ioAck),
    .AIoAddrErr(ioErr),
    .ATest16p  (test)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] misoS;
  logic        ackS, errS;
  logic [15:0] samp [256];
  logic [63:0] expQ [$];

  // ------------------------------------------------------------ scoreboard
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkMasked(input string name, input logic [63:0] got,
                             input logic [63:0] exp, input logic [63:0] care);
    checks++;
    if ((got & care) !== (exp & care)) begin
      errors++;
      $display("FAIL %s: got %h expected %h (care %h)", name, got, exp, care);
    end
  endtask

  // --------------------------------------------------------------- drivers
  // One clock cycle: inputs applied after the falling edge, outputs sampled
  // 1ns later, committed at the following rising edge.
  task automatic cyc(input logic [15:0] a, input logic [3:0] w, input logic [3:0] r,
                     input logic [63:0] d, input logic [15:0] t, input logic e);
    @(negedge clk);
    ioAddr = a; ioWr = w; ioRd = r; ioMosi = d; test = t; clkEn = e;
    #1;
    misoS = ioMiso; ackS = ioAck; errS = ioErr;
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rstN = 1'b0; clkEn = 1'b0; ioWr = '0; ioRd = '0; ioMosi = '0;
    #1;
    check("reset ack", ioAck, 1'b0);
    check("reset miso", ioMiso, 64'h0);
    repeat (n) @(negedge clk);
    rstN = 1'b1;
  endtask

  function automatic logic [63:0] mkCtrl(input logic [15:0] m, input logic [15:0] v,
                                         input logic [7:0] p, input logic ab, input logic arm);
    return {arm, ab, 22'b0, p, v, m};
  endfunction

  // Arm with the given trigger, then feed samp[0..n-1], one per enabled cycle.
  task automatic capture(input logic [15:0] m, input logic [15:0] v, input logic [7:0] p,
                         input int n, input bit randEn);
    cyc(Base, 4'hF, 4'h0, mkCtrl(m, v, p, 1'b0, 1'b1), 16'h0, 1'b1);
    for (int i = 0; i < n; ) begin
      logic e;
      e = randEn ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc(Base, 4'h0, 4'h0, 64'h0, samp[i], e);
      if (e) i++;
    end
  endtask

  // Model: find the first matching sample, count the samples the block
  // keeps, and derive STATUS and the oldest-first read sequence from that.
  task automatic verify(input logic [15:0] m, input logic [15:0] v, input logic [7:0] p,
                        input int n, input bit randEn, input string tag);
    int k, pe, total, st, wp, rp, start, nReads;
    bit wrapd;
    logic [63:0] expStatus;
    k = -1;
    for (int i = 0; i < n; i++)
      if (k < 0 && ((samp[i] ^ v) & m) == 16'h0) k = i;
    pe = int'(p) % D;
    if (k < 0) begin
      st = 1; total = n;
    end else if (n >= k + 1 + pe) begin
      st = 3; total = k + 1 + pe;
    end else begin
      st = 2; total = n;
    end
    wp    = total % D;
    wrapd = (total >= D);
    rp    = (st == 3 && wrapd) ? wp : 0;
    expStatus = {31'b0, wrapd, 8'(rp), 8'(wp), 8'((k < 0) ? 0 : k % D), 6'b0, 2'(st)};
    cyc(Base, 4'h0, 4'h1, 64'h0, 16'h0, 1'b0);
    checkMasked({tag, " status"}, misoS, expStatus,
                (k < 0) ? ~64'h0000_0000_0000_FF00 : ~64'h0);
    if (st == 3) begin
      start  = wrapd ? total - D : 0;
      nReads = wrapd ? D : total;
      for (int i = 0; i < nReads; i++)
        expQ.push_back({40'b0, 8'((rp + i) % D), samp[start + i]});
      while (expQ.size() > 0) begin
        logic e;
        e = randEn ? ($urandom_range(0, 3) != 0) : 1'b1;
        cyc(Base + 16'd1, 4'h0, 4'h4, 64'h0, 16'h0, e);
        check({tag, " data"}, misoS, expQ[0]);
        if (e) void'(expQ.pop_front());
      end
    end else begin
      cyc(Base + 16'd1, 4'h0, 4'h2, 64'h0, 16'h0, 1'b1);
      check({tag, " data not done"}, misoS, 64'h0);
    end
  endtask

  // ------------------------------------------------------- decode vectors
  typedef struct {
    logic [15:0] addr;
    logic [3:0]  wr;
    logic [3:0]  rd;
    logic [63:0] mosi;
    logic        expAck;
    logic        expErr;
    logic [63:0] expMiso;
  } TVec;

  TVec vecs [10];

  initial begin
    logic [63:0] armAll;
    logic [15:0] m, v;
    logic [7:0]  p;
    int n, mode;

    armAll = 64'h8000_0000_0000_0000;
    // Applied in IDLE with STATUS = write ptr 2, everything else 0.
    vecs[0] = '{Base,          4'h0, 4'h1, 64'h0,  1'b1, 1'b0, 64'h0000_0000_0002_0000};
    vecs[1] = '{Base + 16'd1,  4'h0, 4'h4, 64'h0,  1'b1, 1'b0, 64'h0};
    vecs[2] = '{Base + 16'd1,  4'h1, 4'h0, armAll, 1'b1, 1'b1, 64'h0};
    vecs[3] = '{Base,          4'h2, 4'h8, armAll, 1'b1, 1'b1, 64'h0};
    vecs[4] = '{Base + 16'd2,  4'h0, 4'h1, 64'h0,  1'b0, 1'b0, 64'h0};
    vecs[5] = '{Base + 16'd2,  4'hF, 4'h0, armAll, 1'b0, 1'b0, 64'h0};
    vecs[6] = '{Base - 16'd1,  4'h0, 4'h1, 64'h0,  1'b0, 1'b0, 64'h0};
    vecs[7] = '{Base,          4'h0, 4'h0, armAll, 1'b0, 1'b0, 64'h0};
    vecs[8] = '{Base,          4'h0, 4'h1, 64'h0,  1'b1, 1'b0, 64'h0000_0000_0002_0000};
    vecs[9] = '{Base,          4'h0, 4'h8, 64'h0,  1'b1, 1'b0, 64'h0000_0000_0002_0000};

    rstN = 1'b1; clkEn = 1'b0; ioAddr = '0; ioMosi = '0; ioWr = '0; ioRd = '0; test = '0;
    doReset(2);
    cyc(Base, 4'h0, 4'h1, 64'h0, 16'h0, 1'b1);
    check("reset status", misoS, 64'h0);

    // Abort + arm together while in POST: IDLE, the POST sample still counted.
    cyc(Base, 4'h1, 4'h0, mkCtrl(16'h0, 16'h0, 8'd10, 1'b0, 1'b1), 16'h0, 1'b1);
    cyc(Base, 4'h0, 4'h0, 64'h0, 16'h0077, 1'b1);
    cyc(Base, 4'h0, 4'h1, 64'h0, 16'h0, 1'b0);
    check("post status", misoS, 64'h0000_0000_0001_0002);
    cyc(Base, 4'h1, 4'h0, mkCtrl(16'h0, 16'h0, 8'd10, 1'b1, 1'b1), 16'h0078, 1'b1);
    cyc(Base, 4'h0, 4'h1, 64'h0, 16'h0, 1'b1);
    check("abort status", misoS, 64'h0000_0000_0002_0000);

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].mosi, 16'h0, 1'b1);
      check($sformatf("vec%0d ack", i), ackS, vecs[i].expAck);
      check($sformatf("vec%0d err", i), errS, vecs[i].expErr);
      check($sformatf("vec%0d miso", i), misoS, vecs[i].expMiso);
    end

    // mask=0, post=3: four samples, oldest first from index 0.
    doReset(1);
    for (int i = 0; i < 6; i++) samp[i] = 16'h1000 + 16'(i);
    capture(16'h0000, 16'h0000, 8'd3, 6, 1'b0);
    cyc(Base, 4'h0, 4'h1, 64'h0, 16'h0, 1'b0);
    check("first-sample status", misoS, 64'h0000_0000_0004_0003);
    verify(16'h0000, 16'h0000, 8'd3, 6, 1'b0, "first-sample");

    // Ramp with exact match on 0xAA, post=2: wrapped buffer.
    doReset(1);
    for (int i = 0; i < 200; i++) samp[i] = 16'(i);
    capture(16'hFFFF, 16'h00AA, 8'd2, 200, 1'b0);
    cyc(Base, 4'h0, 4'h1, 64'h0, 16'h0, 1'b0);
    check("ramp status", misoS, 64'h0000_0001_2D2D_2A03);
    cyc(Base + 16'd1, 4'h0, 4'h1, 64'h0, 16'h0, 1'b0);
    check("ramp first read", misoS, 64'h0000_0000_002D_006D);
    verify(16'hFFFF, 16'h00AA, 8'd2, 200, 1'b1, "ramp");

    // Clock enable low while ARMED with a matching sample: nothing moves.
    doReset(1);
    samp[0] = 16'h1111; samp[1] = 16'h2222; samp[2] = 16'h3333;
    capture(16'hFFFF, 16'h5555, 8'd0, 3, 1'b0);
    repeat (10) cyc(Base, 4'h0, 4'h0, 64'h0, 16'h5555, 1'b0);
    cyc(Base, 4'h0, 4'h1, 64'h0, 16'h5555, 1'b0);
    check("enable-low status", misoS, 64'h0000_0000_0003_0001);
    cyc(Base, 4'h0, 4'h0, 64'h0, 16'h5555, 1'b1);
    cyc(Base, 4'h0, 4'h1, 64'h0, 16'h0, 1'b0);
    check("late trigger status", misoS, 64'h0000_0000_0004_0303);
    cyc(Base + 16'd1, 4'h0, 4'h1, 64'h0, 16'h0, 1'b1);
    check("late trigger data", misoS, 64'h0000_0000_0000_1111);

    // Reset pulse during POST discards the capture.
    for (int i = 0; i < 3; i++) samp[i] = 16'hA000 + 16'(i);
    capture(16'h0000, 16'h0000, 8'd20, 3, 1'b0);
    cyc(Base, 4'h0, 4'h1, 64'h0, 16'h0, 1'b0);
    check("pre-reset status", misoS, 64'h0000_0000_0003_0002);
    doReset(1);
    cyc(Base, 4'h0, 4'h1, 64'h0, 16'h0, 1'b1);
    check("post-reset status", misoS, 64'h0);
    cyc(Base + 16'd1, 4'h0, 4'h1, 64'h0, 16'h0, 1'b1);
    check("post-reset data", misoS, 64'h0);

    // Randomized captures.
    for (int r = 0; r < 12; r++) begin
      mode = $urandom_range(0, 2);
      n    = $urandom_range(1, 200);
      for (int i = 0; i < n; i++) samp[i] = 16'($urandom);
      v = 16'($urandom);
      case (mode)
        0:       m = 16'h0000;
        1:       m = 16'(16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
        default: begin
          m = 16'hFFFF;
          samp[$urandom_range(0, n - 1)] = v;
        end
      endcase
      p = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 255));
      capture(m, v, p, n, 1'b1);
      verify(m, v, p, n, 1'b1, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
